// File: rtl/fetch_prefetch.sv
// fetch_prefetch: Wishbone classic instruction prefetcher with a DEPTH-entry buffer.
// One bus transaction at a time; a consumer-side jump flushes the buffer and redirects fetch.
module fetch_prefetch #(
    parameter logic [31:0] PC_RESET_VECTOR = 32'h0000_0000,
    parameter int          DEPTH           = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        cyc_o,
    output logic        stb_o,
    output logic        we_o,
    output logic [31:0] adr_o,
    output logic [31:0] dat_o,
    input  logic [31:0] dat_i,
    input  logic        ack_i,
    input  logic        err_i,
    output logic [31:0] PC_O,
    output logic [31:0] IR_O,
    output logic        fault_o,
    output logic        execute,
    input  logic        ins_busy,
    input  logic        jump,
    input  logic [31:0] jump_target
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     adr_q, adr_d;
    logic [AW:0]     occ_q, occ_d;
    logic [AW-1:0]   rptr_q, rptr_d, wptr_q, wptr_d;
    logic [31:0]     pc_mem [DEPTH];
    logic [31:0]     ir_mem [DEPTH];
    logic [DEPTH-1:0] flt_mem;
    logic            term, pop, jump_taken, push;

    assign term       = ack_i | err_i;
    assign execute    = occ_q != '0;
    assign pop        = execute & ~ins_busy;
    assign jump_taken = pop & jump;
    // Data returned in the same cycle as a taken jump belongs to the old stream.
    assign push       = (state_q == REQ) & term & ~jump_taken;

    assign cyc_o   = state_q != IDLE;
    assign stb_o   = cyc_o;
    assign we_o    = 1'b0;
    assign dat_o   = '0;
    assign adr_o   = adr_q;
    assign PC_O    = execute ? pc_mem[rptr_q] : '0;
    assign IR_O    = execute ? ir_mem[rptr_q] : '0;
    assign fault_o = execute & flt_mem[rptr_q];

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE) state_d = (!jump_taken && occ_q < FULL) ? REQ : IDLE;
        else if (term) state_d = IDLE;
        else if (state_q == REQ && jump_taken) state_d = DRAIN;
        adr_d      = (state_q == IDLE) ? fetch_pc_q : adr_q;
        fetch_pc_d = jump_taken ? (jump_target & 32'hFFFF_FFFC) : push ? fetch_pc_q + 32'd4 : fetch_pc_q;
        occ_d      = jump_taken ? '0 : occ_q + (AW + 1)'(push) - (AW + 1)'(pop);
        rptr_d     = jump_taken ? '0 : rptr_q + AW'(pop);
        wptr_d     = jump_taken ? '0 : wptr_q + AW'(push);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= PC_RESET_VECTOR;
            adr_q      <= PC_RESET_VECTOR;
            occ_q      <= '0;
            rptr_q     <= '0;
            wptr_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            adr_q      <= adr_d;
            occ_q      <= occ_d;
            rptr_q     <= rptr_d;
            wptr_q     <= wptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wptr_q]  <= fetch_pc_q;
            ir_mem[wptr_q]  <= dat_i;
            flt_mem[wptr_q] <= err_i;
        end
    end
endmodule

// File: tb/tb_fetch_prefetch.sv
// tb_fetch_prefetch: directed phases plus random traffic checked against a queue-based
// transaction model of the prefetcher (expected bus address, buffer contents, head outputs).
module tb_fetch_prefetch;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RV    = 32'h0000_0000;

    logic        clk = 1'b0, rst = 1'b0;
    logic        cyc_o, stb_o, we_o, ack_i, err_i, fault_o, execute, ins_busy, jump;
    logic [31:0] adr_o, dat_o, dat_i, PC_O, IR_O, jump_target;

    fetch_prefetch #(.PC_RESET_VECTOR(RV), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o),
        .dat_o(dat_o), .dat_i(dat_i), .ack_i(ack_i), .err_i(err_i), .PC_O(PC_O), .IR_O(IR_O),
        .fault_o(fault_o), .execute(execute), .ins_busy(ins_busy), .jump(jump),
        .jump_target(jump_target)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
        logic        f;
    } ent_t;

    ent_t        q[$];
    int          total = 0, bad = 0;
    logic        busy = 1'b0, keep = 1'b0, was_rst = 1'b1;
    logic [31:0] fetch_pc = RV, exp_adr = RV, err_at = 32'hFFFF_FFFF;
    int          wait_left = 0, wait_lo = 0, wait_hi = 0;
    int          busy_pct = 0, jump_pct = 0, err_pct = 0, stray_pct = 0, mode = 0;
    logic        rst_k = 1'b0, force_ack = 1'b0, prev_cyc = 1'b0;
    logic        jumped = 1'b0, got_pc = 1'b0, got_adr = 1'b0;
    int          starts = 0, seen_c = 0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock cycle: check outputs against the model, drive inputs, advance the model.
    task automatic step();
        logic consume, jt, term, start;
        ent_t e;
        @(negedge clk);
        chk1("execute", execute, q.size() != 0);
        if (q.size() != 0) begin
            chk("pc_head", PC_O, q[0].pc);
            chk("ir_head", IR_O, q[0].ir);
            chk1("fault_head", fault_o, q[0].f);
        end
        chk1("cyc", cyc_o, busy);
        chk1("stb", stb_o, busy);
        if (busy) chk("adr", adr_o, exp_adr);
        if (was_rst) begin
            chk("rst_adr", adr_o, RV);
            chk("rst_pc", PC_O, 32'h0);
            chk("rst_ir", IR_O, 32'h0);
            chk1("rst_fault", fault_o, 1'b0);
            chk1("we", we_o, 1'b0);
            chk("dat_o", dat_o, 32'h0);
        end
        if (jumped && !got_pc && execute) begin
            got_pc = 1'b1;
            chk("jump_head", PC_O, 32'h100);
        end
        if (jumped && !got_adr && cyc_o && !prev_cyc) begin
            got_adr = 1'b1;
            chk("jump_adr", adr_o, 32'h100);
        end
        if (execute && PC_O == 32'hC && fault_o) seen_c++;
        if (cyc_o && !prev_cyc) begin
            starts++;
            wait_left = int'($urandom_range(wait_lo, wait_hi));
        end
        prev_cyc = cyc_o;
        rst = rst_k;
        ins_busy = $urandom_range(0, 99) < busy_pct;
        jump = $urandom_range(0, 99) < jump_pct;
        jump_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom;
        if (mode == 1) begin
            ins_busy = !(cyc_o && adr_o == 32'h8 && !jumped);
            jump = !ins_busy;
            jump_target = 32'h103;
        end
        ack_i = 1'b0;
        err_i = 1'b0;
        dat_i = $urandom;
        if (cyc_o) begin
            if (wait_left == 0) begin
                err_i = ($urandom_range(0, 99) < err_pct) || (adr_o == err_at);
                ack_i = !err_i;
                dat_i = mem(adr_o);
            end else wait_left--;
        end else if (force_ack || $urandom_range(0, 99) < stray_pct) ack_i = 1'b1;
        if (!rst) begin
            q.delete();
            busy = 1'b0;
            fetch_pc = RV;
            exp_adr = RV;
            was_rst = 1'b1;
        end else begin
            was_rst = 1'b0;
            consume = q.size() != 0 && !ins_busy;
            jt = consume && jump;
            term = busy && (ack_i || err_i);
            start = !busy && q.size() < DEPTH && !jt;
            if (consume) void'(q.pop_front());
            if (term && keep && !jt) begin
                e.pc = exp_adr;
                e.ir = mem(exp_adr);
                e.f = err_i;
                q.push_back(e);
                fetch_pc += 32'd4;
            end
            if (jt) begin
                q.delete();
                fetch_pc = {jump_target[31:2], 2'b00};
                if (busy && !term) keep = 1'b0;
                if (mode == 1) jumped = 1'b1;
            end
            if (term) busy = 1'b0;
            if (start) begin
                busy = 1'b1;
                keep = 1'b1;
                exp_adr = fetch_pc;
            end
        end
    endtask

    task automatic do_reset();
        rst_k = 1'b0;
        step();
        step();
        rst_k = 1'b1;
    endtask

    initial begin
        ins_busy = 1'b0; jump = 1'b0; jump_target = '0; ack_i = 1'b0; err_i = 1'b0; dat_i = '0;
        do_reset();
        step();
        // zero-wait streaming with a consumer that never stalls
        repeat (40) step();
        // consumer stalled long enough to fill the buffer, then released
        do_reset();
        busy_pct = 100;
        starts = 0;
        repeat (20) step();
        chk("full_fetches", starts, 4);
        busy_pct = 0;
        repeat (20) step();
        // bus error on 0xC is delivered in order as a faulting entry
        do_reset();
        err_at = 32'hC;
        seen_c = 0;
        repeat (20) step();
        chk("err_c_seen", seen_c, 1);
        err_at = 32'hFFFF_FFFF;
        // jump to 0x103 while a 3-wait read of 0x8 is outstanding
        do_reset();
        wait_lo = 3;
        wait_hi = 3;
        mode = 1;
        repeat (40) step();
        mode = 0;
        chk1("jump_done", jumped, 1'b1);
        chk1("jump_seen", got_pc & got_adr, 1'b1);
        // reset in REQ, then a late ack while idle
        do_reset();
        for (int i = 0; i < 10 && !busy; i++) step();
        chk1("req_start", busy, 1'b1);
        rst_k = 1'b0;
        step();
        rst_k = 1'b1;
        force_ack = 1'b1;
        step();
        force_ack = 1'b0;
        repeat (10) step();
        // random traffic: stalls, jumps (some near the top of memory), errors, stray acks
        wait_lo = 0;
        wait_hi = 3;
        busy_pct = 40;
        jump_pct = 15;
        err_pct = 10;
        stray_pct = 10;
        repeat (3000) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
